buffer_to_mpf_sm: RTL and testbench
===================================

# buffer_to_mpf_SM

Write-side counterpart of the read path (`mpf_to_buffer_SM` plus `buffer_512_to_64`).
- Accepts a stream of 64-bit result words from the processing core.
- Packs them into 512-bit cache lines.
- Issues `eREQ_WRLINE_I` requests on MPF channel 1 to consecutive line addresses starting at a destination line address.
- Counts write responses and asserts `done` once every line is acknowledged.
- Instantiated in `app_afu` alongside the read path. The destination address comes from the CSR at MMIO 2 and the length from the CSR at MMIO 4.

## Interface
Parameters:
- `LINE_FIFO_DEPTH`, default 2: packed-line buffer depth between packer and write issuer. Must be a power of 2 and at least 2.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-low reset (`app_afu` drives `!reset`).
- `run`  in  1: start pulse; sampled only in IDLE or DONE.
- `data_length`  in  64: transfer size in bytes; latched on accepted `run`.
- `first_clAddr`  in  `t_cci_clAddr`: first destination line; latched on accepted `run`.
- `in_data`  in  64: result word; word k lands in bits [64k+63:64k] of its line.
- `in_valid`  in  1: `in_data` valid.
- `in_ready`  out  1: word accepted when `in_valid && in_ready`.
- `c1Tx`  out  `t_if_cci_mpf_c1_Tx`: registered write request.
- `c1TxAlmFull`  in  1: channel 1 almost full.
- `c1Rx`  in  `t_if_cci_c1_Rx`: write responses.
- `busy`  out  1: high in RUN and WAIT_ACK.
- `done`  out  1: high in DONE.

## Operation
- **Derived counts.** On `run` accepted: `total_words = (data_length + 7) >> 3` and `total_lines = (data_length + 63) >> 6`, both 32-bit. Only `data_length[37:0]` is used; upper bits are ignored. All counters clear.
- **States:** IDLE, RUN, WAIT_ACK, DONE.
  - IDLE → RUN on `run`.
  - When `total_lines == 0`, `run` goes directly to DONE and no write is issued.
  - RUN → WAIT_ACK when `lines_sent == total_lines`.
  - WAIT_ACK → DONE when `acks == total_lines`. This transition can occur in the same cycle as the last issue.
  - DONE → RUN on a new `run`.
  - `run` in RUN or WAIT_ACK is ignored.
- **Packer.** `in_ready = (state == RUN) && !line_fifo_full && (words_accepted < total_words)`.
  - When the 8th word of a line is accepted, the line is pushed to the FIFO.
  - When the final word leaves a line partial, the line is pushed on that cycle with the unfilled words zero.
- **Issuer.** When the FIFO is not empty, `!c1TxAlmFull`, and `lines_sent < total_lines`:
  - pop the FIFO;
  - drive `c1Tx.valid = 1` for one cycle;
  - header from `cci_mpf_c1_genReqHdr(eREQ_WRLINE_I, first_clAddr + lines_sent, t_cci_mdata'(lines_sent[15:0]), cci_mpf_defaultReqHdrParams())`;
  - increment `lines_sent`.
- **Acks.** Each `c1Rx.rspValid` with `hdr.resp_type == eRSP_WRLINE` increments `acks` by 1. Acks are counted in RUN and WAIT_ACK and ignored otherwise.
- **Address arithmetic.** The line address wraps modulo `2^$bits(t_cci_clAddr)` with no error.

## Timing
- **Reset values:** `c1Tx.valid = 0`, `in_ready = 0`, `busy = 0`, `done = 0`, state IDLE, all counters and the FIFO cleared.
- **Reset mid-transfer:** `c1Tx.valid` is low from the next edge. Later responses are ignored.
- **Latency:** the 8th word is accepted at edge N, the line enters the FIFO at N, and `c1Tx.valid` is high in cycle N+1 at the earliest.
- **Issue rate:** one write per cycle while lines are queued and `c1TxAlmFull` is low.
- **Almost-full:** `c1TxAlmFull` sampled high blocks issue in that cycle. The FIFO then fills and `in_ready` falls.
- **Simultaneous push and pop** on a full FIFO is allowed; the full flag stays asserted.
- `in_ready` is combinational from registered state only, with no path from `in_valid`.
- `done` stays high until the next accepted `run` or reset.

## Structure
- Put these in a shared package, `buffer_to_mpf_pkg`:
  - `t_state` enum;
  - `WORDS_PER_LINE = 8`, `WORD_BITS = 64`;
  - 32-bit counter typedef `t_line_cnt`.
- Make the sub-module `buffer_64_to_512` (packer plus line FIFO), mirroring `buffer_512_to_64`.
  - Ports: `clk`, `rst` (active-low), `clr`, `data_in[63:0]`, `wr_enable`, `last`, `data_out[511:0]`, `rd_enable`, `empty`, `full`.
- Keep the state machine, counters and c1 header generation in `buffer_to_mpf_SM`.

## Test plan
- **Single line:** `data_length = 64`, `first_clAddr = 0x1000`, words 1..8 streamed back-to-back → one write to line 0x1000 with data `0x0000000000000008…0000000000000001` (word 8 in bits [511:448]), `mdata = 0`. `done` rises the cycle after the ack.
- **Partial line:** `data_length = 100` → 13 words accepted, then `in_ready` low. Two writes go to lines A and A+1, and line A+1 holds words 9..13 in bits [319:0] with zeros above. Two acks → DONE.
- **Back-pressure:** 4 lines, `c1TxAlmFull` held high for 20 cycles after the first line → no `c1Tx.valid` during the stall. `in_ready` drops once 2 lines are queued. All 4 writes issue on consecutive cycles after release.
- **Zero length:** `data_length = 0`, `run` → DONE next cycle, no `c1Tx.valid`, `in_ready` never high.
- **Ack timing:** 3 lines with acks delayed 50 cycles and returned out of order → state stays WAIT_ACK until the 3rd ack, then DONE. A `run` pulsed during WAIT_ACK is ignored.
- **Reset mid-run:** reset asserted after 1 of 4 lines → all outputs at reset values next cycle. The late ack is ignored, and a new `run` with `data_length = 64` completes normally.

Source files
------------

// File: rtl/buffer_to_mpf_pkg.sv
// Shared types for the write path (buffer_to_mpf_sm and buffer_64_to_512).
// Also holds local stand-ins for the CCI-P / MPF channel 1 types and header helpers,
// reduced to the fields this path drives or inspects.
package buffer_to_mpf_pkg;

    localparam int unsigned WORDS_PER_LINE = 8;
    localparam int unsigned WORD_BITS      = 64;
    localparam int unsigned LINE_BITS      = WORDS_PER_LINE * WORD_BITS;
    localparam int unsigned CL_ADDR_BITS   = 42;
    localparam int unsigned MDATA_BITS     = 16;

    typedef logic [31:0] t_line_cnt;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StWaitAck = 2'd2,
        StDone    = 2'd3
    } t_state;

    typedef logic [CL_ADDR_BITS-1:0] t_cci_clAddr;
    typedef logic [MDATA_BITS-1:0]   t_cci_mdata;
    typedef logic [LINE_BITS-1:0]    t_cci_clData;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRFENCE  = 4'h4
    } t_cci_c1_req;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4
    } t_cci_c1_rsp;

    typedef struct packed {
        logic checkLoadStoreOrder;
        logic addrIsVirtual;
    } t_cci_mpf_ReqMemHdrParams;

    typedef struct packed {
        t_cci_c1_req req_type;
        logic        checkLoadStoreOrder;
        logic        addrIsVirtual;
        logic        sop;
        t_cci_clAddr address;
        t_cci_mdata  mdata;
    } t_cci_mpf_c1_ReqMemHdr;

    typedef struct packed {
        t_cci_mpf_c1_ReqMemHdr hdr;
        t_cci_clData           data;
        logic                  valid;
    } t_if_cci_mpf_c1_Tx;

    typedef struct packed {
        t_cci_c1_rsp resp_type;
        t_cci_mdata  mdata;
    } t_cci_c1_RspMemHdr;

    typedef struct packed {
        t_cci_c1_RspMemHdr hdr;
        logic              rspValid;
    } t_if_cci_c1_Rx;

    function automatic t_cci_mpf_ReqMemHdrParams cci_mpf_defaultReqHdrParams();
        t_cci_mpf_ReqMemHdrParams p;
        p.checkLoadStoreOrder = 1'b1;
        p.addrIsVirtual       = 1'b1;
        return p;
    endfunction

    function automatic t_cci_mpf_c1_ReqMemHdr cci_mpf_c1_genReqHdr(
        input t_cci_c1_req              req_type,
        input t_cci_clAddr              address,
        input t_cci_mdata               mdata,
        input t_cci_mpf_ReqMemHdrParams params
    );
        t_cci_mpf_c1_ReqMemHdr h;
        h                     = '0;
        h.req_type            = req_type;
        h.checkLoadStoreOrder = params.checkLoadStoreOrder;
        h.addrIsVirtual       = params.addrIsVirtual;
        h.sop                 = 1'b1;
        h.address             = address;
        h.mdata               = mdata;
        return h;
    endfunction

endpackage

// File: rtl/buffer_64_to_512.sv
// Packs 64-bit words into 512-bit lines and queues finished lines in a small FIFO.
// Ports:
//   clk, rst (sync, active-low), clr (sync clear of packer and FIFO)
//   data_in/wr_enable : word input; last marks the final word of the transfer
//   data_out/rd_enable: head line of the FIFO and its pop strobe
//   empty/full        : FIFO status
module buffer_64_to_512
    import buffer_to_mpf_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [WORD_BITS-1:0] data_in,
    input  logic                 wr_enable,
    input  logic                 last,
    output logic [LINE_BITS-1:0] data_out,
    input  logic                 rd_enable,
    output logic                 empty,
    output logic                 full
);

    localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IDX_BITS = $clog2(WORDS_PER_LINE);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(WORDS_PER_LINE - 1);
    localparam logic [PTR_BITS:0]   FULL_CNT = (PTR_BITS + 1)'(DEPTH);

    logic [IDX_BITS-1:0] word_idx_q;
    logic [LINE_BITS-1:0] partial_q;
    logic [LINE_BITS-1:0] line_next;
    logic [LINE_BITS-1:0] mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_BITS:0]   count_q;
    logic push, push_ok, pop;

    // Words above the current index are always zero because the line is cleared on push,
    // so a short final line comes out zero-padded.
    always_comb begin
        line_next = partial_q;
        line_next[word_idx_q * WORD_BITS +: WORD_BITS] = data_in;
    end

    assign push    = wr_enable && ((word_idx_q == LAST_IDX) || last);
    assign pop     = rd_enable && !empty;
    assign push_ok = push && (!full || pop);

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign data_out = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            word_idx_q <= '0;
            partial_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (push) begin
                word_idx_q <= '0;
                partial_q  <= '0;
            end else if (wr_enable) begin
                word_idx_q <= word_idx_q + 1'b1;
                partial_q  <= line_next;
            end
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= line_next;
    end

endmodule

// File: rtl/buffer_to_mpf_sm.sv
// Write-side state machine: packs result words into lines, issues WRLINE_I requests on
// MPF channel 1 to consecutive lines starting at first_clAddr, and counts write responses.
// Ports:
//   clk, reset (sync, active-low), run (start pulse, honoured in IDLE/DONE)
//   data_length (bytes), first_clAddr : latched on an accepted run
//   in_data/in_valid/in_ready         : 64-bit word stream
//   c1Tx/c1TxAlmFull/c1Rx             : MPF channel 1 request/response
//   busy (RUN or WAIT_ACK), done (DONE)
module buffer_to_mpf_sm
    import buffer_to_mpf_pkg::*;
#(
    parameter int unsigned LINE_FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [63:0]       data_length,
    input  t_cci_clAddr       first_clAddr,
    input  logic [63:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output t_if_cci_mpf_c1_Tx c1Tx,
    input  logic              c1TxAlmFull,
    input  t_if_cci_c1_Rx     c1Rx,
    output logic              busy,
    output logic              done
);

    t_state      state_q, state_d;
    t_line_cnt   total_words_q, total_lines_q;
    t_line_cnt   words_q, words_d, lines_q, lines_d, acks_q, acks_d;
    t_cci_clAddr first_addr_q;

    logic [38:0] len;
    t_line_cnt   new_words, new_lines;
    logic        run_ok, accept, last_word, issue, ack;
    logic        fifo_empty, fifo_full;
    t_cci_clData fifo_data;
    logic        unused_bits;

    // Only 38 length bits matter; the response mdata is not needed to count acks.
    assign unused_bits = ^{data_length[63:38], c1Rx.hdr.mdata};

    assign len       = {1'b0, data_length[37:0]};
    assign new_words = t_line_cnt'((len + 39'd7) >> 3);
    assign new_lines = t_line_cnt'((len + 39'd63) >> 6);

    assign run_ok    = run && ((state_q == StIdle) || (state_q == StDone));
    assign in_ready  = (state_q == StRun) && !fifo_full && (words_q < total_words_q);
    assign accept    = in_valid && in_ready;
    assign last_word = (words_q + 32'd1) == total_words_q;
    assign issue     = (state_q == StRun) && !fifo_empty && !c1TxAlmFull
                       && (lines_q < total_lines_q);
    assign ack       = c1Rx.rspValid && (c1Rx.hdr.resp_type == eRSP_WRLINE)
                       && ((state_q == StRun) || (state_q == StWaitAck));

    assign busy = (state_q == StRun) || (state_q == StWaitAck);
    assign done = (state_q == StDone);

    buffer_64_to_512 #(
        .DEPTH (LINE_FIFO_DEPTH)
    ) u_packer (
        .clk       (clk),
        .rst       (reset),
        .clr       (run_ok),
        .data_in   (in_data),
        .wr_enable (accept),
        .last      (last_word),
        .data_out  (fifo_data),
        .rd_enable (issue),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        words_d = words_q;
        lines_d = lines_q;
        acks_d  = acks_q;
        if (run_ok) begin
            words_d = '0;
            lines_d = '0;
            acks_d  = '0;
        end else begin
            if (accept) words_d = words_q + 32'd1;
            if (issue)  lines_d = lines_q + 32'd1;
            if (ack)    acks_d  = acks_q + 32'd1;
        end
    end

    // Transitions use next-state counts so the last issue and the final ack can land on
    // the same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (run) state_d = (new_lines == '0) ? StDone : StRun;
            end
            StRun: begin
                if (lines_d == total_lines_q) begin
                    state_d = (acks_d == total_lines_q) ? StDone : StWaitAck;
                end
            end
            StWaitAck: begin
                if (acks_d == total_lines_q) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            total_words_q <= '0;
            total_lines_q <= '0;
            words_q       <= '0;
            lines_q       <= '0;
            acks_q        <= '0;
            first_addr_q  <= '0;
            c1Tx          <= '0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            lines_q <= lines_d;
            acks_q  <= acks_d;
            if (run_ok) begin
                total_words_q <= new_words;
                total_lines_q <= new_lines;
                first_addr_q  <= first_clAddr;
            end
            c1Tx.valid <= issue;
            if (issue) begin
                c1Tx.hdr  <= cci_mpf_c1_genReqHdr(eREQ_WRLINE_I,
                                                  first_addr_q + t_cci_clAddr'(lines_q),
                                                  t_cci_mdata'(lines_q[15:0]),
                                                  cci_mpf_defaultReqHdrParams());
                c1Tx.data <= fifo_data;
            end
        end
    end

endmodule

// File: tb/tb_buffer_to_mpf_sm.sv
// Bench for buffer_to_mpf_sm: expected writes are queued when a transfer is started and
// compared as c1Tx.valid appears; acks are returned by the directed sequences.
module tb_buffer_to_mpf_sm;
    import buffer_to_mpf_pkg::*;

    typedef logic [511:0] t_vec;
    typedef struct {
        t_cci_clAddr addr;
        t_cci_mdata  mdata;
        t_cci_clData data;
    } t_exp;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic [63:0]       data_length;
    t_cci_clAddr       first_clAddr;
    logic [63:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    t_if_cci_mpf_c1_Tx c1Tx;
    logic              c1TxAlmFull;
    t_if_cci_c1_Rx     c1Rx;
    logic              busy;
    logic              done;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   writes_seen = 0;
    int   write_cyc[$];
    t_exp exp_q[$];
    t_exp e_mon;
    logic stall = 1'b0;
    logic watch_ready = 1'b0;

    buffer_to_mpf_sm #(
        .LINE_FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .data_length  (data_length),
        .first_clAddr (first_clAddr),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .c1Tx         (c1Tx),
        .c1TxAlmFull  (c1TxAlmFull),
        .c1Rx         (c1Rx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input t_vec obs, input t_vec exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (c1Tx.valid) begin
            write_cyc.push_back(cyc);
            writes_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", t_vec'(1), t_vec'(0));
            end else begin
                e_mon = exp_q.pop_front();
                check("wr_type", t_vec'(c1Tx.hdr.req_type), t_vec'(eREQ_WRLINE_I));
                check("wr_addr", t_vec'(c1Tx.hdr.address), t_vec'(e_mon.addr));
                check("wr_mdata", t_vec'(c1Tx.hdr.mdata), t_vec'(e_mon.mdata));
                check("wr_data", c1Tx.data, e_mon.data);
            end
        end
        if (stall)       check("stall_valid", t_vec'(c1Tx.valid), t_vec'(0));
        if (watch_ready) check("zero_len_ready", t_vec'(in_ready), t_vec'(0));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Word idx of the transfer carries value seed + idx.
    task automatic push_lines(input int nlines, input int nwords, input t_cci_clAddr base,
                              input logic [63:0] seed);
        t_exp e;
        for (int l = 0; l < nlines; l++) begin
            e.addr  = base + t_cci_clAddr'(l);
            e.mdata = t_cci_mdata'(l);
            e.data  = '0;
            for (int j = 0; j < 8; j++) begin
                if (l * 8 + j < nwords) e.data[j*64 +: 64] = seed + 64'(l * 8 + j);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic start(input logic [63:0] len, input t_cci_clAddr addr);
        run          = 1'b1;
        data_length  = len;
        first_clAddr = addr;
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    task automatic stream(input int n, input logic [63:0] seed);
        for (int i = 0; i < n; i++) begin
            int k;
            k        = 0;
            in_valid = 1'b1;
            in_data  = seed + 64'(i);
            @(negedge clk);
            while (!in_ready && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) begin
                check("stream_timeout", t_vec'(0), t_vec'(1));
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k;
        k = 0;
        while (writes_seen < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("write_count", t_vec'(writes_seen), t_vec'(n));
    endtask

    task automatic send_rsp(input t_cci_c1_rsp typ, input int mdata);
        c1Rx.rspValid      = 1'b1;
        c1Rx.hdr.resp_type = typ;
        c1Rx.hdr.mdata     = t_cci_mdata'(mdata);
        @(posedge clk); #1;
        c1Rx.rspValid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("wait_done", t_vec'(done), t_vec'(1));
    endtask

    initial begin
        int base;
        reset        = 1'b0;
        run          = 1'b0;
        data_length  = '0;
        first_clAddr = '0;
        in_data      = '0;
        in_valid     = 1'b0;
        c1TxAlmFull  = 1'b0;
        c1Rx         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", t_vec'(c1Tx.valid), t_vec'(0));
        check("rst_ready", t_vec'(in_ready), t_vec'(0));
        check("rst_busy", t_vec'(busy), t_vec'(0));
        check("rst_done", t_vec'(done), t_vec'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        // Single full line, words 1..8.
        push_lines(1, 8, 42'h1000, 64'd1);
        start(64'd64, 42'h1000);
        check("single_busy", t_vec'(busy), t_vec'(1));
        stream(8, 64'd1);
        wait_writes(1, 20);
        check("single_done_pre", t_vec'(done), t_vec'(0));
        send_rsp(eRSP_WRLINE, 0);
        check("single_done_post", t_vec'(done), t_vec'(1));

        // Partial final line: 100 bytes -> 13 words, 2 lines.
        base = writes_seen;
        push_lines(2, 13, 42'h2_0000, 64'h100);
        start(64'd100, 42'h2_0000);
        stream(13, 64'h100);
        check("partial_ready_low", t_vec'(in_ready), t_vec'(0));
        wait_writes(base + 2, 20);
        send_rsp(eRSP_WRLINE, 0);
        check("partial_not_done", t_vec'(done), t_vec'(0));
        send_rsp(eRSP_WRLINE, 1);
        wait_done(5);

        // Back-pressure: 4 lines, almost-full held 20 cycles after the first write.
        base = writes_seen;
        push_lines(4, 32, 42'h3000, 64'hC0DE_0000_0000_0000);
        start(64'd256, 42'h3000);
        fork
            stream(32, 64'hC0DE_0000_0000_0000);
            begin
                wait_writes(base + 1, 100);
                c1TxAlmFull = 1'b1;
                stall       = 1'b1;
                repeat (20) @(posedge clk);
                #1;
                check("bp_ready_low", t_vec'(in_ready), t_vec'(0));
                check("bp_held", t_vec'(writes_seen), t_vec'(base + 1));
                c1TxAlmFull = 1'b0;
                stall       = 1'b0;
            end
        join
        wait_writes(base + 4, 100);
        if (write_cyc.size() >= base + 4) begin
            check("bp_after_stall", t_vec'(write_cyc[base+1] - write_cyc[base] > 20),
                  t_vec'(1));
            check("bp_consecutive", t_vec'(write_cyc[base+2] - write_cyc[base+1]), t_vec'(1));
        end
        for (int i = 0; i < 4; i++) send_rsp(eRSP_WRLINE, i);
        wait_done(5);

        // Zero length, started from DONE.
        base        = writes_seen;
        watch_ready = 1'b1;
        start(64'd0, 42'h4000);
        check("zero_done", t_vec'(done), t_vec'(1));
        check("zero_busy", t_vec'(busy), t_vec'(0));
        repeat (5) @(posedge clk);
        #1;
        watch_ready = 1'b0;
        check("zero_no_write", t_vec'(writes_seen), t_vec'(base));

        // Delayed, out-of-order acks; destination wraps past the top line address.
        base = writes_seen;
        push_lines(3, 24, '1, 64'h5000);
        start(64'd192, '1);
        stream(24, 64'h5000);
        wait_writes(base + 3, 20);
        check("ack_busy", t_vec'(busy), t_vec'(1));
        start(64'd64, 42'h7000);
        repeat (50) @(posedge clk);
        #1;
        check("ack_wait_busy", t_vec'(busy), t_vec'(1));
        check("ack_wait_done", t_vec'(done), t_vec'(0));
        check("ack_run_ignored", t_vec'(writes_seen), t_vec'(base + 3));
        send_rsp(eRSP_WRLINE, 2);
        send_rsp(eRSP_WRFENCE, 0);
        send_rsp(eRSP_WRLINE, 0);
        check("ack_two_busy", t_vec'(busy), t_vec'(1));
        check("ack_two_done", t_vec'(done), t_vec'(0));
        send_rsp(eRSP_WRLINE, 1);
        check("ack_three_done", t_vec'(done), t_vec'(1));

        // Reset mid-run after the first of 4 lines.
        base = writes_seen;
        push_lines(4, 32, 42'h8000, 64'h9000);
        start(64'd256, 42'h8000);
        stream(11, 64'h9000);
        wait_writes(base + 1, 20);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_valid", t_vec'(c1Tx.valid), t_vec'(0));
        check("mid_rst_ready", t_vec'(in_ready), t_vec'(0));
        check("mid_rst_busy", t_vec'(busy), t_vec'(0));
        check("mid_rst_done", t_vec'(done), t_vec'(0));
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        send_rsp(eRSP_WRLINE, 0);
        check("late_ack_done", t_vec'(done), t_vec'(0));
        check("late_ack_busy", t_vec'(busy), t_vec'(0));
        base = writes_seen;
        push_lines(1, 8, 42'hA000, 64'hBEEF);
        start(64'd64, 42'hA000);
        stream(8, 64'hBEEF);
        wait_writes(base + 1, 20);
        send_rsp(eRSP_WRLINE, 0);
        wait_done(5);
        check("sb_empty", t_vec'(exp_q.size()), t_vec'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
